// File: rtl/sr04_emulador.sv
`timescale 1ns/1ps
// sr04_emulador -- sensor-side model of the HC-SR04 trigger/echo protocol.
//
// Accepts a trigger pulse from the distance-counter logic and checks that it
// is at least TRIG_MIN_US wide. After a fixed burst delay it drives an echo
// pulse that is distancia*US_PER_CM us wide, then enforces a hold-off dead
// time. All widths are exact multiples of TICK_DIV clk cycles.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   distancia  target distance in cm, latched when a trigger is accepted
//   trigger    asynchronous trigger input (2-flop synchronized)
//   echo       echo pulse back to the initiator
//   busy       high whenever the FSM is not in IDLE
//   trig_ok    one-cycle strobe when a valid trigger is accepted
//   rango_err  last accepted distancia was 0 or above MAX_CM
//
// Build option:
//   SR04_TIMEOUT_ECHO_EN  defined: out-of-range targets give a TIMEOUT_US echo.
//                         undefined: out-of-range targets give no echo at all.
module sr04_emulador #(
  parameter int TICK_DIV    = 50,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 200,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] distancia,
  input  logic       trigger,
  output logic       echo,
  output logic       busy,
  output logic       trig_ok,
  output logic       rango_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The us counter must hold the longest interval of any state, including the
  // full 255 cm product, so the echo width never truncates.
  localparam int MAX_US = max2(max2(max2(TRIG_MIN_US, BURST_US), max2(HOLDOFF_US, TIMEOUT_US)),
                               255 * US_PER_CM);
  localparam int US_W   = max2(16, $clog2(MAX_US + 1));
  localparam int PW     = max2(1, $clog2(TICK_DIV));

  localparam logic [US_W-1:0] TRIG_LIM  = US_W'(TRIG_MIN_US);
  localparam logic [US_W-1:0] BURST_LIM = US_W'(BURST_US);
  localparam logic [US_W-1:0] HOLD_LIM  = US_W'(HOLDOFF_US);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  state_t          state;
  logic            trig_p0, trig_p1, trig_p2;
  logic            vld_p0, vld_p1, vld_p2;
  logic [PW-1:0]   presc;
  logic [US_W-1:0] us_cnt;
  logic [7:0]      dist_lat;

  logic            tick;
  logic            rise;
  logic            fall;
  logic [US_W-1:0] us_adv;
  logic [US_W-1:0] echo_us;

  function automatic logic [US_W-1:0] sat_us(input logic [US_W-1:0] cnt,
                                             input logic [US_W-1:0] lim);
    return (cnt > lim) ? lim : cnt;
  endfunction

  function automatic logic out_of_range(input logic [7:0] d);
    return (d == 8'd0) || ({24'd0, d} > 32'(MAX_CM));
  endfunction

  function automatic logic [US_W-1:0] echo_len(input logic [7:0] d, input logic oor);
    return oor ? US_W'(TIMEOUT_US) : US_W'(d) * US_W'(US_PER_CM);
  endfunction

  assign tick    = (presc == PW'(TICK_DIV - 1));
  // Count including the tick landing on this edge, so an interval of N us
  // ends exactly N*TICK_DIV edges after the state was entered.
  assign us_adv  = us_cnt + {{(US_W-1){1'b0}}, tick};
  // The vld chain marks when trig_p2 holds a real sample; a trigger that is
  // already high when reset releases therefore never looks like a rise.
  assign rise    = vld_p2 &  trig_p1 & ~trig_p2;
  assign fall    = vld_p2 & ~trig_p1 &  trig_p2;
  assign echo_us = echo_len(dist_lat, rango_err);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      echo      <= 1'b0;
      busy      <= 1'b0;
      trig_ok   <= 1'b0;
      rango_err <= 1'b0;
      trig_p0   <= 1'b0;
      trig_p1   <= 1'b0;
      trig_p2   <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      presc     <= '0;
      us_cnt    <= '0;
    end else begin
      // synchronizer stage 0 -> 1 -> edge-detect stage 2
      trig_p0 <= trigger;
      trig_p1 <= trig_p0;
      trig_p2 <= trig_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;

      trig_ok <= 1'b0;
      presc   <= tick ? '0 : presc + PW'(1);
      us_cnt  <= us_adv;

      case (state)
        IDLE: begin
          presc  <= '0;
          us_cnt <= '0;
          if (rise) begin
            state <= TRIG_HI;
            busy  <= 1'b1;
          end
        end

        TRIG_HI: begin
          us_cnt <= sat_us(us_adv, TRIG_LIM);
          if (fall) begin
            presc  <= '0;
            us_cnt <= '0;
            if (us_adv >= TRIG_LIM) begin
              state     <= BURST;
              trig_ok   <= 1'b1;
              dist_lat  <= distancia;
              rango_err <= out_of_range(distancia);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        BURST: begin
          if (us_adv == BURST_LIM) begin
            presc  <= '0;
            us_cnt <= '0;
`ifdef SR04_TIMEOUT_ECHO_EN
            state <= ECHO;
            echo  <= 1'b1;
`else
            if (rango_err) begin
              state <= HOLDOFF;
            end else begin
              state <= ECHO;
              echo  <= 1'b1;
            end
`endif
          end
        end

        ECHO: begin
          if (us_adv == echo_us) begin
            presc  <= '0;
            us_cnt <= '0;
            state  <= HOLDOFF;
            echo   <= 1'b0;
          end
        end

        HOLDOFF: begin
          if (us_adv == HOLD_LIM) begin
            presc  <= '0;
            us_cnt <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          echo  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_emulador.sv
`timescale 1ns/1ps
module tb_sr04_emulador;

  localparam int TD   = 2;
  localparam int TMIN = 10;
  localparam int BUS  = 4;
  localparam int UPC  = 3;
  localparam int HUS  = 5;
  localparam int MAXC = 200;
  localparam int TOUS = 700;
`ifdef SR04_TIMEOUT_ECHO_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif
  localparam int TOW = (TO_EN != 0) ? TOUS * TD : 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] distancia = 8'd0;
  logic       trigger = 1'b0;
  logic       echo, busy, trig_ok, rango_err;

  sr04_emulador #(
    .TICK_DIV(TD), .TRIG_MIN_US(TMIN), .BURST_US(BUS), .US_PER_CM(UPC),
    .MAX_CM(MAXC), .TIMEOUT_US(TOUS), .HOLDOFF_US(HUS)
  ) dut (
    .clk(clk), .reset(reset), .distancia(distancia), .trigger(trigger),
    .echo(echo), .busy(busy), .trig_ok(trig_ok), .rango_err(rango_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int d; int rk; int rw; int ck; int cd;
    int acc; int width; int rango;
  } vec_t;

  typedef struct {
    int tok_n; int tok_k; int er_n; int er_k; int ew;
    int bf_k; int brise_n; int rango; int busy_hi;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int model_rango = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference rules: a trigger is valid if it lasted at least TMIN whole us;
  // in-range targets echo d*UPC us, out-of-range ones the timeout (or nothing).
  task automatic predict(input int w, input int d, input int prev_rango,
                         output int acc, output int width, output int rango);
    int oor;
    acc   = ((w / TD) >= TMIN) ? 1 : 0;
    oor   = (d == 0 || d > MAXC) ? 1 : 0;
    width = (acc == 0) ? 0 : ((oor != 0) ? TOW : d * UPC * TD);
    rango = (acc == 0) ? prev_rango : oor;
  endtask

  task automatic run_meas(input int w, input int d, input int rk, input int rw,
                          input int ck, input int cd, input int win, output obs_t o);
    int prev_e, prev_b;
    o = '{default: 0};
    o.tok_k = -1; o.er_k = -1; o.ew = -1; o.bf_k = -1;
    distancia = d[7:0];
    @(negedge clk);
    trigger = 1'b1;
    repeat (w) @(negedge clk);
    o.busy_hi = int'(busy);
    trigger = 1'b0;
    prev_e = int'(echo);
    prev_b = int'(busy);
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (trig_ok) begin
        o.tok_n++;
        if (o.tok_k < 0) o.tok_k = k;
      end
      if (echo && prev_e == 0) begin
        o.er_n++;
        if (o.er_k < 0) o.er_k = k;
      end
      if (!echo && prev_e == 1 && o.ew < 0) o.ew = k - o.er_k;
      if (!busy && prev_b == 1 && o.bf_k < 0) o.bf_k = k;
      if (busy && prev_b == 0) o.brise_n++;
      prev_e = int'(echo);
      prev_b = int'(busy);
      if (rk > 0 && k == rk) trigger = 1'b1;
      if (rk > 0 && k == rk + rw) trigger = 1'b0;
      if (ck > 0 && k == ck) distancia = cd[7:0];
    end
    trigger = 1'b0;
    o.rango = int'(rango_err);
    repeat (3) @(negedge clk);
  endtask

  // Event positions are counted in clk edges from the raw trigger fall.
  task automatic run_check(input string tag, input vec_t v);
    obs_t o;
    int rise_k, busy_k, win;
    rise_k = 3 + BUS * TD;
    busy_k = (v.acc != 0) ? rise_k + v.width + HUS * TD : 3;
    win    = busy_k + 40;
    run_meas(v.w, v.d, v.rk, v.rw, v.ck, v.cd, win, o);
    chk({tag, "_busy_during_trig"}, o.busy_hi, 1);
    chk({tag, "_trig_ok_count"}, o.tok_n, v.acc);
    if (v.acc != 0) chk({tag, "_trig_ok_latency"}, o.tok_k, 3);
    chk({tag, "_echo_pulses"}, o.er_n, (v.width > 0) ? 1 : 0);
    if (v.width > 0) begin
      chk({tag, "_echo_rise"}, o.er_k, rise_k);
      chk({tag, "_echo_width"}, o.ew, v.width);
    end
    chk({tag, "_busy_fall"}, o.bf_k, busy_k);
    chk({tag, "_busy_restart"}, o.brise_n, 0);
    chk({tag, "_rango_err"}, o.rango, v.rango);
    model_rango = v.rango;
  endtask

  task automatic reset_mid(input string tag, input int w, input int d, input int at_k,
                           input int echo_before, input int rango_before);
    distancia = d[7:0];
    @(negedge clk);
    trigger = 1'b1;
    repeat (w) @(negedge clk);
    trigger = 1'b0;
    repeat (at_k) @(negedge clk);
    chk({tag, "_echo_before"}, echo, echo_before);
    chk({tag, "_rango_before"}, rango_err, rango_before);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_echo_after"}, echo, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_rango_after"}, rango_err, 0);
    reset = 1'b1;
    model_rango = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[12];
    vec_t v;
    int acc, width, rango, w, d;

    // w, d, retrig_k, retrig_w, chg_k, chg_d | acc, width, rango
    tab[0]  = '{24,  10,  0,  0, 0, 0, 1,   60, 0};
    tab[1]  = '{18,  10,  0,  0, 0, 0, 0,    0, 0};
    tab[2]  = '{20,  10,  0,  0, 0, 0, 1,   60, 0};
    tab[3]  = '{24,  10, 30, 25, 0, 0, 1,   60, 0};
    tab[4]  = '{24,  10, 73,  4, 0, 0, 1,   60, 0};
    tab[5]  = '{20,   0,  0,  0, 0, 0, 1,  TOW, 1};
    tab[6]  = '{18,  50,  0,  0, 0, 0, 0,    0, 1};
    tab[7]  = '{20, 201,  0,  0, 0, 0, 1,  TOW, 1};
    tab[8]  = '{22, 200,  0,  0, 6, 5, 1, 1200, 0};
    tab[9]  = '{300,  1,  0,  0, 0, 0, 1,    6, 0};
    tab[10] = '{24,  10, 78, 20, 0, 0, 1,   60, 0};
    tab[11] = '{20, 255,  0,  0, 0, 0, 1,  TOW, 1};

    // Reset with trigger already high: outputs clear, and no measurement starts.
    reset = 1'b0;
    trigger = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_echo", echo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_trig_ok", trig_ok, 0);
    chk("reset_rango_err", rango_err, 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("trig_high_from_reset_busy", busy, 0);
    trigger = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("v%0d", i), tab[i]);
    end

    reset_mid("rst_burst", 20, 0, 6, 0, 1);
    reset_mid("rst_echo", 24, 50, 30, 1, 0);
    v = '{24, 10, 0, 0, 0, 0, 1, 60, 0};
    run_check("after_reset", v);

    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(14, 26));
      if ($urandom_range(0, 3) == 0)
        d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(201, 255));
      else
        d = int'($urandom_range(1, MAXC));
      predict(w, d, model_rango, acc, width, rango);
      v = '{w, d, 0, 0, 0, 0, acc, width, rango};
      run_check($sformatf("rnd%0d_w%0d_d%0d", i, w, d), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
